// File: rtl/forward_stall_ctrl_if.sv
// forward_stall_ctrl_if: ID-stage hazard query and forward/stall response bundle
interface forward_stall_ctrl_if #(
    parameter int AW = 5,
    parameter int DEPTH = 3
);
    localparam int SW = $clog2(DEPTH + 1);
    logic          id_valid;
    logic          id_wr_en;
    logic          id_is_load;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic          flush_i;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic          stall;
    logic          bubble;
    logic [15:0]   stall_cnt;
    modport master (
        output id_valid, id_wr_en, id_is_load, id_rs1, id_rs2, id_rd,
               id_rs1_used, id_rs2_used, flush_i,
        input  fwd_a, fwd_b, stall, bubble, stall_cnt
    );
    modport slave (
        input  id_valid, id_wr_en, id_is_load, id_rs1, id_rs2, id_rd,
               id_rs1_used, id_rs2_used, flush_i,
        output fwd_a, fwd_b, stall, bubble, stall_cnt
    );
endinterface

// File: rtl/forward_stall_ctrl.sv
// forward_stall_ctrl: tracks in-flight destination registers, selects operand
// forwarding sources and raises load-use stalls for the ID stage.
module forward_stall_ctrl #(
    parameter int AW = 5,
    parameter int DEPTH = 3,
    parameter int LOAD_LAT = 1
) (
    input logic clk,
    input logic rst,
    forward_stall_ctrl_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ld;
    logic [AW-1:0]    rd [DEPTH];
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;
    logic [SW-1:0]    fa;
    logic [SW-1:0]    fb;
    logic             haz;
    logic             stall;
    logic             bubble;
    logic [15:0]      cnt;
    // Walking from oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        m1 = '0;
        m2 = '0;
        fa = '0;
        fb = '0;
        haz = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            m1[i] = v[i] && rd[i] == bus.id_rs1 && bus.id_rs1 != '0 && bus.id_rs1_used;
            m2[i] = v[i] && rd[i] == bus.id_rs2 && bus.id_rs2 != '0 && bus.id_rs2_used;
            if (m1[i]) fa = (i >= LOAD_LAT || !ld[i]) ? SW'(i + 1) : '0;
            if (m2[i]) fb = (i >= LOAD_LAT || !ld[i]) ? SW'(i + 1) : '0;
            haz = haz | ((m1[i] | m2[i]) && i < LOAD_LAT && ld[i]);
        end
    end
    assign stall         = haz & bus.id_valid & ~bus.flush_i;
    assign bubble        = stall | bus.flush_i;
    assign bus.stall     = stall;
    assign bus.bubble    = bubble;
    assign bus.fwd_a     = (bus.id_valid && !stall) ? fa : '0;
    assign bus.fwd_b     = (bus.id_valid && !stall) ? fb : '0;
    assign bus.stall_cnt = cnt;
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
            rd[i] <= rd[i-1];
            ld[i] <= ld[i-1];
        end
        rd[0] <= bus.id_rd;
        ld[0] <= bus.id_is_load;
        if (rst) begin
            v   <= '0;
            cnt <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) v[i] <= v[i-1];
            v[0] <= bus.id_valid & bus.id_wr_en & (bus.id_rd != '0) & ~bubble;
            cnt  <= cnt + 16'((stall && cnt != 16'hFFFF) ? 1 : 0);
        end
    end
endmodule

// File: tb/tb_forward_stall_ctrl.sv
// tb_forward_stall_ctrl: directed checks of forwarding, load-use stall, flush and counter saturation
module tb_forward_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    forward_stall_ctrl_if #(.AW(5), .DEPTH(3)) bus ();
    forward_stall_ctrl #(.AW(5), .DEPTH(3), .LOAD_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set(input logic vl, input logic wr, input logic lo, input logic [4:0] r1,
                       input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] d, input logic fl);
        bus.id_valid = vl;
        bus.id_wr_en = wr;
        bus.id_is_load = lo;
        bus.id_rs1 = r1;
        bus.id_rs1_used = u1;
        bus.id_rs2 = r2;
        bus.id_rs2_used = u2;
        bus.id_rd = d;
        bus.flush_i = fl;
        #1;
    endtask
    task automatic idle();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_stall(input string tag);
        set(1, 1, 1, 0, 0, 0, 0, 7, 0);
        step();
        set(1, 0, 0, 7, 1, 0, 0, 0, 0);
        chk(tag, 16'(bus.stall), 16'd1);
        step();
    endtask
    initial begin
        idle();
        step();
        step();
        rst = 1'b0;
        idle();
        chk("rst_stall", 16'(bus.stall), 0);
        chk("rst_bubble", 16'(bus.bubble), 0);
        chk("rst_fwd_a", 16'(bus.fwd_a), 0);
        chk("rst_fwd_b", 16'(bus.fwd_b), 0);
        chk("rst_cnt", bus.stall_cnt, 0);
        set(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_flush_bubble", 16'(bus.bubble), 1);
        step();
        // ALU result on x5 ages through all three stages
        set(1, 1, 0, 0, 0, 0, 0, 5, 0);
        chk("alu_issue_stall", 16'(bus.stall), 0);
        step();
        set(1, 0, 0, 5, 1, 0, 0, 0, 0);
        chk("alu_fwd_a1", 16'(bus.fwd_a), 1);
        chk("alu_stall", 16'(bus.stall), 0);
        chk("alu_bubble", 16'(bus.bubble), 0);
        step();
        chk("alu_fwd_a2", 16'(bus.fwd_a), 2);
        step();
        chk("alu_fwd_a3", 16'(bus.fwd_a), 3);
        step();
        chk("alu_fwd_a0", 16'(bus.fwd_a), 0);
        // load-use on rs2
        set(1, 1, 1, 0, 0, 0, 0, 7, 0);
        step();
        set(1, 0, 0, 0, 0, 7, 1, 0, 0);
        chk("lu_stall", 16'(bus.stall), 1);
        chk("lu_bubble", 16'(bus.bubble), 1);
        chk("lu_fwd_b", 16'(bus.fwd_b), 0);
        chk("lu_cnt0", bus.stall_cnt, 0);
        step();
        chk("lu_cnt1", bus.stall_cnt, 1);
        chk("lu_stall_end", 16'(bus.stall), 0);
        chk("lu_fwd_b2", 16'(bus.fwd_b), 2);
        chk("lu_fwd_a0", 16'(bus.fwd_a), 0);
        // youngest writer wins
        idle();
        step();
        step();
        step();
        set(1, 1, 0, 0, 0, 0, 0, 3, 0);
        step();
        set(1, 1, 0, 0, 0, 0, 0, 9, 0);
        step();
        set(1, 1, 0, 0, 0, 0, 0, 3, 0);
        step();
        set(1, 0, 0, 3, 1, 3, 1, 0, 0);
        chk("yw_fwd_a", 16'(bus.fwd_a), 1);
        chk("yw_fwd_b", 16'(bus.fwd_b), 1);
        chk("yw_stall", 16'(bus.stall), 0);
        set(1, 0, 0, 3, 1, 9, 1, 0, 0);
        chk("ab_fwd_a", 16'(bus.fwd_a), 1);
        chk("ab_fwd_b", 16'(bus.fwd_b), 2);
        // flush beats load-use hazard and kills the ID write
        idle();
        step();
        step();
        step();
        set(1, 1, 1, 0, 0, 0, 0, 7, 0);
        step();
        set(1, 1, 0, 7, 1, 0, 0, 8, 1);
        chk("fl_stall", 16'(bus.stall), 0);
        chk("fl_bubble", 16'(bus.bubble), 1);
        step();
        chk("fl_cnt", bus.stall_cnt, 1);
        set(1, 0, 0, 7, 1, 8, 1, 0, 0);
        chk("fl_killed_fwd_b", 16'(bus.fwd_b), 0);
        chk("fl_load_fwd_a", 16'(bus.fwd_a), 2);
        chk("fl_stall2", 16'(bus.stall), 0);
        // x0 and unused operands never forward
        idle();
        step();
        step();
        step();
        set(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        set(1, 0, 0, 0, 1, 0, 1, 0, 0);
        chk("x0_fwd_a", 16'(bus.fwd_a), 0);
        chk("x0_stall", 16'(bus.stall), 0);
        set(1, 1, 0, 0, 0, 0, 0, 4, 0);
        step();
        set(1, 0, 0, 4, 0, 0, 0, 0, 0);
        chk("unused_fwd_a", 16'(bus.fwd_a), 0);
        set(1, 0, 0, 4, 1, 0, 0, 0, 0);
        chk("used_fwd_a", 16'(bus.fwd_a), 1);
        set(0, 0, 0, 4, 1, 0, 0, 0, 0);
        chk("novalid_fwd_a", 16'(bus.fwd_a), 0);
        set(0, 0, 0, 4, 1, 0, 0, 0, 1);
        chk("novalid_bubble", 16'(bus.bubble), 1);
        step();
        // counter saturation
        idle();
        force dut.cnt = 16'hFFFC;
        #1;
        release dut.cnt;
        do_stall("sat_s1");
        do_stall("sat_s2");
        chk("sat_fffe", bus.stall_cnt, 16'hFFFE);
        do_stall("sat_s3");
        chk("sat_ffff", bus.stall_cnt, 16'hFFFF);
        do_stall("sat_s4");
        chk("sat_hold", bus.stall_cnt, 16'hFFFF);
        // reset in the middle of a stall
        set(1, 1, 1, 0, 0, 0, 0, 7, 0);
        step();
        set(1, 0, 0, 7, 1, 0, 0, 0, 0);
        rst = 1'b1;
        chk("mid_stall", 16'(bus.stall), 1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 16'(bus.stall), 0);
        chk("mid_rst_cnt", bus.stall_cnt, 0);
        chk("mid_rst_fwd_a", 16'(bus.fwd_a), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/forward_stall_ctrl.md
FORWARD_STALL_CTRL -- requirements
Module: forward_stall_ctrl

Interface
REQ-001 SHALL provide parameter AW, default 5, register-address width.
REQ-002 SHALL provide parameter DEPTH, default 3, number of tracked in-flight stages after ID (stage 0 = EX, stage DEPTH-1 = oldest before RF write); legal range 1..7.
REQ-003 SHALL provide parameter LOAD_LAT, default 1, number of stages (0..LOAD_LAT-1) in which load data is not yet available; legal range 0..DEPTH.
REQ-004 SHALL define local SW = clog2(DEPTH+1), the forward-select width.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports id_valid, id_wr_en, id_is_load  in  1 each  ID instruction valid, writes rd, is a load.
REQ-008 SHALL have ports id_rs1, id_rs2, id_rd  in  AW each  ID source and destination addresses.
REQ-009 SHALL have ports id_rs1_used, id_rs2_used  in  1 each  source operand actually read.
REQ-010 SHALL have port flush_i  in  1  taken branch/jump resolved in EX; kill ID instruction.
REQ-011 SHALL have ports fwd_a, fwd_b  out  SW each  0 = register file, k = forward from stage k-1.
REQ-012 SHALL have port stall  out  1  hold PC and IF/ID this cycle.
REQ-013 SHALL have port bubble  out  1  inject NOP into EX this cycle.
REQ-014 SHALL have port stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-015 SHALL hold per stage i a record {v, rd, ld}; records shift i -> i+1 every cycle; record DEPTH-1 is discarded.
REQ-016 Stage 0 SHALL load {id_valid & id_wr_en & (id_rd!=0) & ~bubble, id_rd, id_is_load} each cycle; a bubble loads v=0.
REQ-017 Stage i SHALL match source s when v=1, rd==s, s!=0 and the source is used.
REQ-018 fwd_a SHALL be i+1 for the lowest-index matching stage on id_rs1 with i >= LOAD_LAT or ld=0, else 0; fwd_b likewise on id_rs2; A and B evaluated independently (both may be non-zero simultaneously).
REQ-019 Load-use hazard SHALL be any matching stage i < LOAD_LAT with ld=1 on either used source, when id_valid=1.
REQ-020 stall SHALL equal load-use hazard & ~flush_i; combinational from current state and ID inputs, no added latency.
REQ-021 bubble SHALL equal stall | flush_i.
REQ-022 While stall=1, fwd_a and fwd_b SHALL be 0.
REQ-023 Load-use on a record SHALL clear as it ages past LOAD_LAT-1, so stall lasts at most LOAD_LAT consecutive cycles per hazard.
REQ-024 flush_i and hazard same cycle: flush wins, stall=0, bubble=1.
REQ-025 id_valid=0: stall=0, fwd_a=fwd_b=0, bubble=flush_i.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with stall=1 and saturate at 16'hFFFF.
REQ-027 LOAD_LAT=0 SHALL never stall; all loads forwardable.

Reset
REQ-028 rst=1 SHALL clear all stage v bits and stall_cnt to 0 on the next edge, overriding shift and flush.
REQ-029 After reset: fwd_a=fwd_b=0, stall=0, bubble=flush_i.
REQ-030 rst asserted mid-stall SHALL end the stall on the following cycle.

Verification
REQ-031 DEPTH=3,LOAD_LAT=1: ALU writes x5; next ID reads rs1=x5 -> fwd_a=1, stall=0; one cycle later -> fwd_a=2; then 3; then 0.
REQ-032 Load writes x7; next ID reads rs2=x7 -> stall=1, bubble=1 for exactly 1 cycle, stall_cnt 0->1; next cycle fwd_b=2.
REQ-033 Writes to x3 in stages 0 and 2; ID rs1=rs2=x3 -> fwd_a=fwd_b=1 (youngest wins).
REQ-034 Load-use hazard with flush_i=1 same cycle -> stall=0, bubble=1, stall_cnt unchanged, stage 0 v=0 next cycle.
REQ-035 rd=x0 write then ID reads x0 -> fwd_a=0, stall=0; also id_rs1_used=0 with matching rs1 -> fwd_a=0.
REQ-036 stall_cnt preset to 16'hFFFE via 2 stalls after forced state; further stalls -> holds 16'hFFFF; rst=1 -> 0.
